msg_tx_scheduler: RTL and testbench

Arbitrates the single UART transmitter between the game-control requesters: placement-ready notice, shot address, and shot-result reply. Each granted request becomes a two-byte frame (header, payload) on the UART TX byte interface. With the retry feature compiled in, the block waits for a peer acknowledge and retransmits on timeout. It sits between the game state machine and the UART TX, and owns every byte leaving the board.

---
 rtl/msg_pkg.sv | 46 ++++
 rtl/msg_ack_timer.sv | 53 +++++
 rtl/msg_tx_scheduler.sv | 174 +++++++++++++++++
 tb/tb_msg_tx_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msg_pkg
// Purpose  : Shared types and helpers for the TX message scheduler.
// Revision : 1.0  initial release
// ============================================================================
package msg_pkg;

   typedef enum logic [1:0] {
      MSG_NONE   = 2'b00,
      MSG_READY  = 2'b01,
      MSG_SHOT   = 2'b10,
      MSG_RESULT = 2'b11
   } msg_type_t;

   localparam logic [3:0] HDR_SYNC = 4'b1010;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SEND_HDR = 3'd1,
      ST_WAIT_HDR = 3'd2,
      ST_SEND_PAY = 3'd3,
      ST_WAIT_PAY = 3'd4,
      ST_WAIT_ACK = 3'd5,
      ST_DONE     = 3'd6
   } msg_state_t;

   function automatic logic [7:0] msg_header(input msg_type_t t);
      return {HDR_SYNC, 2'b00, t};
   endfunction

   // Bit order matches {res_done, shot_done, ready_done}.
   function automatic logic [2:0] msg_done_vec(input msg_type_t t);
      logic [2:0] v;
      v = 3'b000;
      case (t)
         MSG_READY:  v = 3'b001;
         MSG_SHOT:   v = 3'b010;
         MSG_RESULT: v = 3'b100;
         default:    v = 3'b000;
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/msg_ack_timer.sv
`default_nettype none
// ============================================================================
// Module   : msg_ack_timer
// Purpose  : Ack-wait timeout counter and retry counter; exists only when
//            MSG_RETRY_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`ifdef MSG_RETRY_EN
module msg_ack_timer #(
   parameter int TIMEOUT_CYCLES = 6_500_000,
   parameter int MAX_RETRY      = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic timeout,
   output logic exhausted
);

   localparam int c_TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int c_RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [c_RTY_W-1:0] c_RTY_MAX  = c_RTY_W'(MAX_RETRY);

   logic [c_TMR_W-1:0] r_timer;
   logic [c_RTY_W-1:0] r_retry;

   assign timeout   = enable && (r_timer == c_TMR_LAST);
   assign exhausted = (r_retry == c_RTY_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_timer <= '0;
         r_retry <= '0;
      end else if (clear) begin
         r_timer <= '0;
         r_retry <= '0;
      end else if (enable) begin
         if (r_timer == c_TMR_LAST) begin
            r_timer <= '0;
            if (!exhausted) begin
               r_retry <= r_retry + c_RTY_W'(1);
            end
         end else begin
            r_timer <= r_timer + c_TMR_W'(1);
         end
      end
   end

endmodule
`endif
`default_nettype wire

// File: rtl/msg_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : msg_tx_scheduler
// Purpose  : Arbitrates game-control requests onto the UART TX as two-byte
//            frames; MSG_RETRY_EN adds ack wait, retransmit and link_err.
// Revision : 1.0  initial release
// ============================================================================
module msg_tx_scheduler
   import msg_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 6_500_000,
   parameter int MAX_RETRY      = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ready_req,
   input  logic       shot_req,
   input  logic [7:0] shot_addr,
   input  logic       res_req,
   input  logic [7:0] res_data,
   output logic       ready_done,
   output logic       shot_done,
   output logic       res_done,
   output logic       tx_fail,
   output logic       busy,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   input  logic       ack_rx,
   output logic       link_err
);

   msg_state_t r_state;
   msg_type_t  r_id;
   logic [7:0] r_payload;
   logic [7:0] r_tx_last;
   logic [2:0] r_done;
   logic       r_busy;
   logic       w_tx_start;
   logic [7:0] w_byte;

   // The strobe is decoded from state so the UART sees it in the cycle after
   // the grant; tx_data otherwise replays the last launched byte.
   assign w_byte     = (r_state == ST_SEND_PAY) ? r_payload : msg_header(r_id);
   assign w_tx_start = ((r_state == ST_SEND_HDR) || (r_state == ST_SEND_PAY)) && !tx_busy;
   assign tx_start   = w_tx_start;
   assign tx_data    = w_tx_start ? w_byte : r_tx_last;
   assign {res_done, shot_done, ready_done} = r_done;
   assign busy       = r_busy;

`ifdef MSG_RETRY_EN
   logic w_tmr_clear;
   logic w_tmr_en;
   logic w_timeout;
   logic w_exhausted;
   logic r_fail;
   logic r_tx_fail;
   logic r_link_err;

   assign w_tmr_clear = (r_state == ST_DONE);
   assign w_tmr_en    = (r_state == ST_WAIT_ACK);

   msg_ack_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .MAX_RETRY      (MAX_RETRY)
   ) u_ack_timer (
      .clk       (clk),
      .rst       (rst),
      .clear     (w_tmr_clear),
      .enable    (w_tmr_en),
      .timeout   (w_timeout),
      .exhausted (w_exhausted)
   );

   assign tx_fail  = r_tx_fail;
   assign link_err = r_link_err;
`else
   wire w_unused_ack = ack_rx;
   localparam int c_unused_cfg = TIMEOUT_CYCLES + MAX_RETRY;

   assign tx_fail  = 1'b0;
   assign link_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_id      <= MSG_NONE;
         r_payload <= 8'h00;
         r_tx_last <= 8'h00;
         r_done    <= 3'b000;
         r_busy    <= 1'b0;
`ifdef MSG_RETRY_EN
         r_fail     <= 1'b0;
         r_tx_fail  <= 1'b0;
         r_link_err <= 1'b0;
`endif
      end else begin
         r_done <= 3'b000;
`ifdef MSG_RETRY_EN
         r_tx_fail <= 1'b0;
`endif
         if (w_tx_start) begin
            r_tx_last <= w_byte;
         end

         case (r_state)
            ST_IDLE: begin
               if (res_req) begin
                  r_id      <= MSG_RESULT;
                  r_payload <= res_data;
                  r_state   <= ST_SEND_HDR;
                  r_busy    <= 1'b1;
               end else if (shot_req) begin
                  r_id      <= MSG_SHOT;
                  r_payload <= shot_addr;
                  r_state   <= ST_SEND_HDR;
                  r_busy    <= 1'b1;
               end else if (ready_req) begin
                  r_id      <= MSG_READY;
                  r_payload <= 8'h00;
                  r_state   <= ST_SEND_HDR;
                  r_busy    <= 1'b1;
               end
            end
            ST_SEND_HDR: if (!tx_busy) r_state <= ST_WAIT_HDR;
            ST_WAIT_HDR: if (!tx_busy) r_state <= ST_SEND_PAY;
            ST_SEND_PAY: if (!tx_busy) r_state <= ST_WAIT_PAY;
            ST_WAIT_PAY: begin
               if (!tx_busy) begin
`ifdef MSG_RETRY_EN
                  r_state <= ST_WAIT_ACK;
`else
                  r_state <= ST_DONE;
                  r_done  <= msg_done_vec(r_id);
`endif
               end
            end
`ifdef MSG_RETRY_EN
            // Ack is tested first so it wins over a coincident timeout.
            ST_WAIT_ACK: begin
               if (ack_rx) begin
                  r_state <= ST_DONE;
                  r_done  <= msg_done_vec(r_id);
               end else if (w_timeout) begin
                  if (w_exhausted) begin
                     r_state   <= ST_DONE;
                     r_done    <= msg_done_vec(r_id);
                     r_fail    <= 1'b1;
                     r_tx_fail <= 1'b1;
                  end else begin
                     r_state <= ST_SEND_HDR;
                  end
               end
            end
`endif
            ST_DONE: begin
`ifdef MSG_RETRY_EN
               if (r_fail) r_link_err <= 1'b1;
               r_fail <= 1'b0;
`endif
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_msg_tx_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_msg_tx_scheduler
// Purpose  : Randomized self-checking bench for msg_tx_scheduler against a
//            frame/timeline model; retry scenarios run when MSG_RETRY_EN is set.
// Revision : 1.0  initial release
// ============================================================================
module tb_msg_tx_scheduler;

   localparam int c_BYTE      = 10;
   localparam int c_TMO       = 100;
   localparam int c_RETRY_MAX = 3;
`ifdef MSG_RETRY_EN
   localparam bit c_RETRY = 1'b1;
`else
   localparam bit c_RETRY = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ready_req = 1'b0, shot_req = 1'b0, res_req = 1'b0;
   logic [7:0] shot_addr = 8'h00, res_data = 8'h00;
   logic       ready_done, shot_done, res_done, tx_fail, busy, tx_start, link_err;
   logic [7:0] tx_data;
   logic       tx_busy;
   logic       ack_rx = 1'b0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ucnt = 0;
   int proto_err = 0;
   int ack_dly = 0;
   int ack_at = -1;
   int n_done;
   bit lerr_exp = 1'b0;

   logic [7:0] byte_q[$];
   int         start_q[$];
   int         dt_q[$];
   int         dc_q[$];
   bit         df_q[$];

   msg_tx_scheduler #(
      .TIMEOUT_CYCLES (c_TMO),
      .MAX_RETRY      (c_RETRY_MAX)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ready_req  (ready_req),
      .shot_req   (shot_req),
      .shot_addr  (shot_addr),
      .res_req    (res_req),
      .res_data   (res_data),
      .ready_done (ready_done),
      .shot_done  (shot_done),
      .res_done   (res_done),
      .tx_fail    (tx_fail),
      .busy       (busy),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .ack_rx     (ack_rx),
      .link_err   (link_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // UART stand-in: busy for c_BYTE cycles starting the cycle after tx_start.
   always @(posedge clk or posedge rst) begin
      if (rst)              ucnt <= 0;
      else if (tx_start)    ucnt <= c_BYTE;
      else if (ucnt > 0)    ucnt <= ucnt - 1;
   end
   assign tx_busy = (ucnt != 0);

   always @(negedge clk) begin
      if (!rst) begin
         if (tx_start) begin
            if (tx_busy) proto_err <= proto_err + 1;
            byte_q.push_back(tx_data);
            start_q.push_back(cyc);
            if ((byte_q.size() % 2 == 0) && ack_dly > 0) ack_at = cyc + ack_dly;
         end
         n_done = int'(ready_done) + int'(shot_done) + int'(res_done);
         if (n_done > 1 || (tx_fail && n_done == 0)) proto_err <= proto_err + 1;
         if (n_done != 0) begin
            dt_q.push_back(res_done ? 2 : (shot_done ? 1 : 0));
            df_q.push_back(tx_fail);
            dc_q.push_back(cyc);
         end
      end
      ack_rx = (cyc == ack_at);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      byte_q.delete(); start_q.delete();
      dt_q.delete(); dc_q.delete(); df_q.delete();
   endtask

   // mask bit0 = ready, bit1 = shot, bit2 = result; ack==0 means never ack.
   task automatic raise(input logic [2:0] mask, input logic [7:0] sa, input logic [7:0] rd,
                        input int ack, output int c);
      @(negedge clk);
      clear_log();
      ack_dly   = ack;
      ack_at    = -1;
      ready_req = mask[0];
      shot_req  = mask[1];
      shot_addr = sa;
      res_req   = mask[2];
      res_data  = rd;
      c = cyc;
   endtask

   task automatic finish_scenario(input logic [2:0] mask, input logic [7:0] sa,
                                  input logic [7:0] rd, input int ack, input int c);
      logic [7:0] exp_byte[$];
      int         exp_start[$];
      int         exp_dt[$];
      int         exp_dc[$];
      bit         exp_df[$];
      logic [2:0] pending;
      int         t, p, dc, att, budget;
      bit         fl;

      // Timeline model: grant at c, header one cycle later, each byte takes
      // c_BYTE busy cycles plus two state cycles, DONE then IDLE between frames.
      t = c + 1;
      p = 0;
      for (int k = 2; k >= 0; k--) begin
         if (mask[k]) begin
            fl  = c_RETRY && (ack == 0);
            att = fl ? c_RETRY_MAX + 1 : 1;
            for (int a = 0; a < att; a++) begin
               exp_byte.push_back(8'(8'hA0 + k + 1));
               exp_byte.push_back(k == 2 ? rd : (k == 1 ? sa : 8'h00));
               exp_start.push_back(t);
               p = t + c_BYTE + 2;
               exp_start.push_back(p);
               t = p + c_BYTE + 2 + c_TMO;
            end
            if (!c_RETRY)  dc = p + c_BYTE + 2;
            else if (fl)   dc = p + c_BYTE + 2 + c_TMO;
            else           dc = p + ack + 1;
            exp_dt.push_back(k);
            exp_df.push_back(fl);
            exp_dc.push_back(dc);
            if (fl) lerr_exp = 1'b1;
            t = dc + 2;
         end
      end

      @(negedge clk);
      check("start_latency", 32'(tx_start), 32'd1);
      check("busy_in_frame", 32'(busy), 32'd1);

      pending = mask;
      budget  = 4000;
      while (pending != 3'b000 && budget > 0) begin
         @(negedge clk);
         budget--;
         if (ready_done) begin pending[0] = 1'b0; ready_req = 1'b0; end
         if (shot_done)  begin pending[1] = 1'b0; shot_req  = 1'b0; end
         if (res_done)   begin pending[2] = 1'b0; res_req   = 1'b0; end
      end
      check("scenario_bound", 32'(pending), 32'd0);
      ready_req = 1'b0; shot_req = 1'b0; res_req = 1'b0;
      repeat (3) @(negedge clk);

      check("busy_idle", 32'(busy), 32'd0);
      check("link_err", 32'(link_err), 32'(lerr_exp));
      check("protocol", 32'(proto_err), 32'd0);
      check("byte_count", 32'(byte_q.size()), 32'(exp_byte.size()));
      if (byte_q.size() == exp_byte.size()) begin
         for (int i = 0; i < exp_byte.size(); i++) begin
            check("tx_byte", 32'(byte_q[i]), 32'(exp_byte[i]));
            check("start_cycle", 32'(start_q[i]), 32'(exp_start[i]));
         end
      end
      check("done_count", 32'(dt_q.size()), 32'(exp_dt.size()));
      if (dt_q.size() == exp_dt.size()) begin
         for (int i = 0; i < exp_dt.size(); i++) begin
            check("done_type", 32'(dt_q[i]), 32'(exp_dt[i]));
            check("done_fail", 32'(df_q[i]), 32'(exp_df[i]));
            check("done_cycle", 32'(dc_q[i]), 32'(exp_dc[i]));
         end
      end
   endtask

   task automatic scenario(input logic [2:0] mask, input logic [7:0] sa,
                           input logic [7:0] rd, input int ack);
      int c;
      raise(mask, sa, rd, ack, c);
      finish_scenario(mask, sa, rd, ack, c);
   endtask

   initial begin
      #900us;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c, n, ack;
      logic [2:0] mask;
      logic [7:0] sa, rd;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_done", 32'({res_done, shot_done, ready_done}), 32'd0);
      check("rst_fail_link", 32'({tx_fail, link_err}), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      scenario(3'b010, 8'h3A, 8'h00, c_RETRY ? 40 : 0);
      scenario(3'b111, 8'h5D, 8'h02, c_RETRY ? 25 : 0);
      if (c_RETRY) begin
         scenario(3'b100, 8'h00, 8'h01, 40);
         scenario(3'b010, 8'h77, 8'h00, 0);
         scenario(3'b001, 8'h00, 8'h00, c_BYTE + 1 + c_TMO);
      end

      // Reset while the payload is on the wire: no done, resend from header.
      raise(3'b010, 8'hC4, 8'h00, c_RETRY ? 40 : 0, c);
      n = 0;
      while (byte_q.size() < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rst_reach_payload", 32'(byte_q.size()), 32'd2);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_tx_data", 32'(tx_data), 32'd0);
      check("async_rst_link_err", 32'(link_err), 32'd0);
      lerr_exp = 1'b0;
      ack_at   = -1;
      repeat (2) @(negedge clk);
      check("rst_no_done", 32'(dt_q.size()), 32'd0);
      clear_log();
      rst = 1'b0;
      c = cyc;
      finish_scenario(3'b010, 8'hC4, 8'h00, c_RETRY ? 40 : 0, c);

      for (int i = 0; i < 6; i++) begin
         mask = 3'($urandom_range(1, 7));
         sa   = 8'($urandom);
         rd   = {6'b0, 2'($urandom)};
         ack  = 0;
         if (c_RETRY && $urandom_range(0, 3) != 0) ack = $urandom_range(c_BYTE + 2, c_BYTE + 1 + c_TMO);
         scenario(mask, sa, rd, ack);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
